// File: rtl/kyber_pkg.sv
// Shared Kyber constants and types: sponge rate, XOF stream size, ring parameters
// and the state encoding of the NTT-domain rejection sampler.
package kyber_pkg;

  localparam int SHAKE128_RATE_BITS  = 1344;
  localparam int SHAKE128_RATE_BYTES = SHAKE128_RATE_BITS / 8;
  localparam int XOF_BLOCKS          = 4;
  localparam int XOF_BITS            = SHAKE128_RATE_BITS * XOF_BLOCKS;
  localparam int N_COEFF             = 256;
  localparam int Q                   = 3329;
  localparam int TRIPLE_BITS         = 24;
  localparam int COEFF_W             = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EMIT1 = 3'd2,
    ST_EMIT2 = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAIL  = 3'd5
  } sample_state_e;

endpackage

// File: rtl/rej_candidate_unpack.sv
// Splits one little-endian byte triple into its two 12-bit candidates and
// flags which of them fall below the modulus.
module rej_candidate_unpack #(
  parameter int Q = kyber_pkg::Q
) (
  input  logic [23:0] triple,
  output logic [11:0] d1,
  output logic [11:0] d2,
  output logic        acc1,
  output logic        acc2
);

  localparam logic [11:0] Q_BOUND = 12'(Q);

  // d1 = b0 | b1[3:0] << 8, d2 = b1[7:4] | b2 << 4: both are plain bit slices.
  assign d1   = triple[11:0];
  assign d2   = triple[23:12];
  assign acc1 = (d1 < Q_BOUND);
  assign acc2 = (d2 < Q_BOUND);

endmodule

// File: rtl/sample_ntt.sv
// Rejection sampler turning a squeezed SHAKE128 string into the 256 NTT-domain
// coefficients of one matrix-A polynomial, streamed over valid/ready.
module sample_ntt
  import kyber_pkg::*;
#(
  parameter int XOF_BITS = kyber_pkg::XOF_BITS,
  parameter int N_COEFF  = kyber_pkg::N_COEFF,
  parameter int Q        = kyber_pkg::Q
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                xof_valid,
  input  logic [XOF_BITS-1:0] xof_bits,
  output logic [11:0]         coeff,
  output logic [7:0]          coeff_idx,
  output logic                coeff_valid,
  input  logic                coeff_ready,
  output logic                done,
  output logic                fail
);

  localparam int N_TRIPLES = XOF_BITS / TRIPLE_BITS;
  localparam int TRIP_W    = $clog2(N_TRIPLES + 1);
  localparam logic [TRIP_W-1:0] LAST_TRIP = TRIP_W'(N_TRIPLES);
  localparam logic [TRIP_W-1:0] TRIP_ONE  = TRIP_W'(1);
  localparam logic [7:0]        LAST_IDX  = 8'(N_COEFF - 1);

  sample_state_e       state_r, state_s;
  logic [XOF_BITS-1:0] buf_r;
  logic [TRIP_W-1:0]   trip_r;
  logic [7:0]          cnt_r;
  logic [11:0]         d1_r, d2_r;
  logic                acc1_r, acc2_r;
  logic [11:0]         d1_s, d2_s;
  logic                acc1_s, acc2_s;
  logic                start_ok_s, hs_s;
  logic                valid_nx_s;
  logic [11:0]         coeff_nx_s;
  logic [7:0]          cnt_nx_s;

  rej_candidate_unpack #(.Q(Q)) u_unpack (
    .triple (buf_r[TRIPLE_BITS-1:0]),
    .d1     (d1_s),
    .d2     (d2_s),
    .acc1   (acc1_s),
    .acc2   (acc2_s)
  );

  assign start_ok_s = start & xof_valid;
  assign hs_s       = coeff_valid & coeff_ready;
  assign cnt_nx_s   = cnt_r + {7'd0, hs_s};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_s;
  end

  // Next-state decode; the last-coefficient check wins over the normal exit.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if (start_ok_s) state_s = ST_FETCH;
        else            state_s = state_r;
      end
      ST_FETCH: begin
        if (trip_r == LAST_TRIP) state_s = ST_FAIL;
        else                     state_s = ST_EMIT1;
      end
      ST_EMIT1: begin
        if (!acc1_r)   state_s = ST_EMIT2;
        else if (hs_s) state_s = (cnt_r == LAST_IDX) ? ST_DONE : ST_EMIT2;
        else           state_s = ST_EMIT1;
      end
      ST_EMIT2: begin
        if (!acc2_r)   state_s = ST_FETCH;
        else if (hs_s) state_s = (cnt_r == LAST_IDX) ? ST_DONE : ST_FETCH;
        else           state_s = ST_EMIT2;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Shift buffer, candidate registers and counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_r  <= '0;
      trip_r <= '0;
      cnt_r  <= '0;
      d1_r   <= '0;
      d2_r   <= '0;
      acc1_r <= 1'b0;
      acc2_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_FAIL: begin
          if (start_ok_s) begin
            buf_r  <= xof_bits;
            trip_r <= '0;
            cnt_r  <= '0;
          end
        end
        ST_FETCH: begin
          if (trip_r != LAST_TRIP) begin
            d1_r   <= d1_s;
            d2_r   <= d2_s;
            acc1_r <= acc1_s;
            acc2_r <= acc2_s;
            buf_r  <= buf_r >> TRIPLE_BITS;
            trip_r <= trip_r + TRIP_ONE;
          end
        end
        ST_EMIT1, ST_EMIT2: cnt_r <= cnt_nx_s;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Output values for the cycle after this edge; FETCH->EMIT1 uses the fresh unpack.
  always_comb begin
    valid_nx_s = 1'b0;
    coeff_nx_s = coeff;
    case (state_s)
      ST_EMIT1: begin
        if (state_r == ST_FETCH) begin
          valid_nx_s = acc1_s;
          coeff_nx_s = d1_s;
        end else begin
          valid_nx_s = acc1_r;
          coeff_nx_s = d1_r;
        end
      end
      ST_EMIT2: begin
        valid_nx_s = acc2_r;
        coeff_nx_s = d2_r;
      end
      default: begin
        valid_nx_s = 1'b0;
        coeff_nx_s = coeff;
      end
    endcase
  end

  // Registered outputs; coeff/coeff_idx hold whenever nothing is offered.
  always_ff @(posedge clk) begin
    if (rst) begin
      coeff       <= 12'd0;
      coeff_idx   <= 8'd0;
      coeff_valid <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
    end else begin
      coeff_valid <= valid_nx_s;
      if (valid_nx_s) begin
        coeff     <= coeff_nx_s;
        coeff_idx <= cnt_nx_s;
      end else begin
        coeff     <= coeff;
        coeff_idx <= coeff_idx;
      end
      done <= (state_s == ST_DONE);
      fail <= (state_s == ST_FAIL);
    end
  end

endmodule

// File: tb/tb_sample_ntt.sv
// Self-checking bench for sample_ntt: byte-level reference model of the
// rejection rule and cycle count, randomized data and backpressure.
module tb_sample_ntt;

  localparam int XB = 5376;
  localparam int NT = XB / 24;
  localparam int NB = XB / 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          xof_valid;
  logic [XB-1:0] xof_bits;
  logic [11:0]   coeff;
  logic [7:0]    coeff_idx;
  logic          coeff_valid;
  logic          coeff_ready;
  logic          done;
  logic          fail;

  sample_ntt #(.XOF_BITS(XB), .N_COEFF(256), .Q(3329)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .xof_valid   (xof_valid),
    .xof_bits    (xof_bits),
    .coeff       (coeff),
    .coeff_idx   (coeff_idx),
    .coeff_valid (coeff_valid),
    .coeff_ready (coeff_ready),
    .done        (done),
    .fail        (fail)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  logic [7:0] bytes_a [NB];
  int   exp_q[$];
  bit   exp_fail;
  int   exp_cycles;
  int   obs_q[$];
  int   first_valid_k;
  int   idx10_cycles;

  // Reference: walk byte triples, accept candidates below q until 256 are taken.
  task automatic build_model();
    int d [2];
    exp_q.delete();
    exp_fail   = 1'b0;
    exp_cycles = 0;
    for (int t = 0; t < NT && exp_q.size() < 256; t++) begin
      d[0] = int'(bytes_a[3*t]) + 256 * (int'(bytes_a[3*t+1]) % 16);
      d[1] = int'(bytes_a[3*t+1]) / 16 + 16 * int'(bytes_a[3*t+2]);
      for (int j = 0; j < 2; j++) begin
        if (exp_q.size() < 256 && d[j] < 3329) begin
          exp_q.push_back(d[j]);
          if (exp_q.size() == 256) exp_cycles = 3 * t + 3 + j;
        end
      end
    end
    if (exp_q.size() < 256) begin
      exp_fail   = 1'b1;
      exp_cycles = 1 + 3 * NT + 1;
    end
    for (int k = 0; k < NB; k++) xof_bits[8*k +: 8] = bytes_a[k];
  endtask

  task automatic fill_bytes(input int kind);
    for (int k = 0; k < NB; k++) begin
      case (kind)
        0:       bytes_a[k] = 8'h00;
        1:       bytes_a[k] = 8'hFF;
        default: bytes_a[k] = 8'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Start one run and follow it to done/fail. mode 0: ready=1, 1: random ready,
  // 2: ready dropped for 5 cycles while idx 10 is offered.
  task automatic run_stream(input string name, input int mode);
    int k, n, stall;
    bit seen_end, held;
    logic [11:0] held_c;
    logic [7:0]  held_i;
    obs_q.delete();
    first_valid_k = -1;
    idx10_cycles  = 0;
    @(negedge clk);
    xof_valid = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 1; n = 0; stall = 0; seen_end = 1'b0; held = 1'b0;
    held_c = 12'd0; held_i = 8'd0;
    while (k < 4000 && !seen_end) begin
      if (done || fail) begin
        seen_end = 1'b1;
      end else begin
        if (held) begin
          checks++;
          if (coeff_valid !== 1'b1 || coeff !== held_c || coeff_idx !== held_i) begin
            failures++;
            $display("FAIL %s_hold: got v=%0b %0d/%0d want v=1 %0d/%0d", name,
                     coeff_valid, coeff, coeff_idx, held_c, held_i);
          end
        end
        if (coeff_valid && first_valid_k < 0) first_valid_k = k;
        if (coeff_valid && coeff_idx == 8'd10) idx10_cycles++;
        case (mode)
          0:       coeff_ready = 1'b1;
          1:       coeff_ready = ($urandom_range(0, 3) != 0);
          default: coeff_ready = !(coeff_valid && coeff_idx == 8'd10 && stall < 5);
        endcase
        if (coeff_valid && coeff_idx == 8'd10 && !coeff_ready) stall++;
        if (coeff_valid && coeff_ready) begin
          checks++;
          if (n >= exp_q.size() || coeff !== 12'(exp_q[n]) || coeff_idx !== n[7:0]) begin
            failures++;
            $display("FAIL %s_coeff: got %0d idx %0d want %0d idx %0d", name, coeff, coeff_idx,
                     (n < exp_q.size()) ? exp_q[n] : -1, n);
          end
          obs_q.push_back(int'(coeff));
          n++;
          held = 1'b0;
        end else if (coeff_valid) begin
          held   = 1'b1;
          held_c = coeff;
          held_i = coeff_idx;
        end else begin
          held = 1'b0;
        end
        @(negedge clk);
        k++;
      end
    end
    coeff_ready = 1'b1;
    checks++;
    if (!seen_end) begin
      failures++;
      $display("FAIL %s_timeout: got no done/fail after %0d cycles want end", name, k);
    end
    checks++;
    if (done !== !exp_fail || fail !== exp_fail) begin
      failures++;
      $display("FAIL %s_flags: got done=%0b fail=%0b want done=%0b fail=%0b", name, done, fail,
               !exp_fail, exp_fail);
    end
    checks++;
    if (n != exp_q.size() || coeff_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_count: got %0d valid=%0b want %0d valid=0", name, n, coeff_valid,
               exp_q.size());
    end
    if (mode == 0) begin
      checks++;
      if (k != exp_cycles) begin
        failures++;
        $display("FAIL %s_latency: got %0d cycles want %0d", name, k, exp_cycles);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; xof_valid = 1'b0; coeff_ready = 1'b1;
    fill_bytes(0);
    build_model();
    repeat (3) @(negedge clk);
    checks++;
    if (coeff !== 12'd0 || coeff_idx !== 8'd0 || coeff_valid !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin
      failures++;
      $display("FAIL reset: got c=%0d i=%0d v=%0b d=%0b f=%0b want all 0", coeff, coeff_idx,
               coeff_valid, done, fail);
    end
    rst   = 1'b0;
    start = 1'b1;
    repeat (6) @(negedge clk);
    start = 1'b0;
    checks++;
    if (coeff_valid !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin
      failures++;
      $display("FAIL start_no_xof: got v=%0b d=%0b f=%0b want 0 0 0", coeff_valid, done, fail);
    end
  endtask

  task automatic test_zero();
    fill_bytes(0);
    build_model();
    run_stream("zero", 0);
  endtask

  task automatic test_pattern();
    fill_bytes(2);
    bytes_a[0] = 8'h01; bytes_a[1] = 8'h02; bytes_a[2] = 8'h03;
    build_model();
    run_stream("pattern", 0);
    checks++;
    if (obs_q.size() < 2 || obs_q[0] != 513 || obs_q[1] != 48 || first_valid_k != 2) begin
      failures++;
      $display("FAIL pattern_first: got %0d,%0d at k=%0d want 513,48 at k=2",
               (obs_q.size() > 0) ? obs_q[0] : -1, (obs_q.size() > 1) ? obs_q[1] : -1, first_valid_k);
    end
  endtask

  task automatic test_boundary();
    fill_bytes(2);
    bytes_a[0] = 8'h00; bytes_a[1] = 8'h1D; bytes_a[2] = 8'hD0;
    bytes_a[3] = 8'h05; bytes_a[4] = 8'h00; bytes_a[5] = 8'h00;
    build_model();
    run_stream("boundary", 1);
    checks++;
    if (obs_q.size() < 2 || obs_q[0] != 3328 || obs_q[1] != 5) begin
      failures++;
      $display("FAIL boundary_first: got %0d,%0d want 3328,5",
               (obs_q.size() > 0) ? obs_q[0] : -1, (obs_q.size() > 1) ? obs_q[1] : -1);
    end
  endtask

  task automatic test_fail_recover();
    fill_bytes(1);
    build_model();
    run_stream("all_ff", 0);
    fill_bytes(0);
    build_model();
    run_stream("recover", 0);
  endtask

  task automatic test_backpressure();
    fill_bytes(2);
    build_model();
    run_stream("backpressure", 2);
    checks++;
    if (idx10_cycles != 6) begin
      failures++;
      $display("FAIL bp_idx10: got %0d valid cycles want 6", idx10_cycles);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    fill_bytes(0);
    build_model();
    @(negedge clk);
    start = 1'b1; xof_valid = 1'b1; coeff_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (k < 1000 && !(coeff_valid && coeff_idx == 8'd100)) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (k >= 1000) begin
      failures++;
      $display("FAIL rst_mid_reach: got no idx 100 in %0d cycles want idx 100", k);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (coeff !== 12'd0 || coeff_idx !== 8'd0 || coeff_valid !== 1'b0 || done !== 1'b0 || fail !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: got c=%0d i=%0d v=%0b d=%0b f=%0b want all 0", coeff, coeff_idx,
               coeff_valid, done, fail);
    end
    rst = 1'b0;
    fill_bytes(2);
    build_model();
    run_stream("after_rst", 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      fill_bytes(2);
      build_model();
      run_stream("random", (r % 2 == 0) ? 1 : 0);
    end
  endtask

  initial begin
    xof_bits = '0;
    test_reset();
    test_zero();
    test_pattern();
    test_boundary();
    test_fail_recover();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
